// File: rtl/conv3x3_window_mac.sv
// Streaming 3x3 window multiply-accumulate stage fed by a three-row line buffer.
// Define CONV_RELU_EN to clamp negative sums to zero in the output register.
module conv3x3_window_mac #(
   parameter int BIT_DEPTH = 8,
   parameter int COLS      = 28,
   parameter int ACC_WIDTH = 21
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BIT_DEPTH-1:0]    row1_in,
   input  logic [BIT_DEPTH-1:0]    row2_in,
   input  logic [BIT_DEPTH-1:0]    row3_in,
   output logic                    lb_shift,
   input  logic                    row_start,
   input  logic                    wt_load,
   input  logic [3:0]              wt_idx,
   input  logic [BIT_DEPTH-1:0]    wt_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_WIDTH-1:0]    out_data,
   output logic [$clog2(COLS)-1:0] out_col
);
   localparam int CW    = $clog2(COLS);
   localparam int PW    = 2*BIT_DEPTH + 1;
   localparam int FULLW = 2*BIT_DEPTH + 5;
   localparam int SW    = (ACC_WIDTH > FULLW) ? ACC_WIDTH : FULLW;

   logic [BIT_DEPTH-1:0]        win_q [3][3];
   logic [BIT_DEPTH-1:0]        win_d [3][3];
   logic signed [BIT_DEPTH-1:0] wt_q [9];
   logic signed [BIT_DEPTH-1:0] wt_d [9];
   logic [CW-1:0]               col_cnt_q, col_cnt_d;
   logic                        win_valid_q, win_valid_d;
   logic [CW-1:0]               win_col_q, win_col_d;
   logic signed [PW-1:0]        prod_q [9];
   logic signed [PW-1:0]        prod_d [9];
   logic                        prod_valid_q, prod_valid_d;
   logic [CW-1:0]               prod_col_q, prod_col_d;
   logic [ACC_WIDTH-1:0]        out_data_q, out_data_d;
   logic                        out_valid_q, out_valid_d;
   logic [CW-1:0]               out_col_q, out_col_d;
   logic                        stall, accept;
   logic [CW-1:0]               acc_idx;
   logic [BIT_DEPTH-1:0]        col_pix [3];
   logic signed [SW-1:0]        sum;

   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = ~stall;
   assign accept    = in_valid & ~stall;
   assign lb_shift  = accept;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_col   = out_col_q;

   // Column counter and S1 window; a row_start column counts as index 0.
   always_comb begin
      col_pix[0]  = row1_in;
      col_pix[1]  = row2_in;
      col_pix[2]  = row3_in;
      acc_idx     = row_start ? '0 : col_cnt_q;
      col_cnt_d   = col_cnt_q;
      win_d       = win_q;
      win_valid_d = win_valid_q;
      win_col_d   = win_col_q;
      if (accept) begin
         col_cnt_d = (acc_idx == CW'(COLS - 1)) ? '0 : acc_idx + CW'(1);
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
            win_d[r][2] = col_pix[r];
         end
      end else if (row_start) begin
         col_cnt_d = '0;
      end
      if (!stall) begin
         win_valid_d = accept && (acc_idx >= CW'(2));
         win_col_d   = acc_idx - CW'(2);
      end
      if (row_start && !accept) win_valid_d = 1'b0;
   end

   // Kernel slots are writable at any edge, stalled or not.
   always_comb begin
      wt_d = wt_q;
      for (int k = 0; k < 9; k++) begin
         if (wt_load && wt_idx == 4'(k)) wt_d[k] = wt_data;
      end
   end

   // S2 products and S3 sum; both hold while the output is stalled.
   always_comb begin
      prod_d       = prod_q;
      prod_valid_d = prod_valid_q;
      prod_col_d   = prod_col_q;
      out_valid_d  = out_valid_q;
      out_col_d    = out_col_q;
      out_data_d   = out_data_q;
      sum          = '0;
      for (int k = 0; k < 9; k++) sum = sum + SW'(prod_q[k]);
      if (!stall) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               prod_d[r*3+c] = $signed({{(PW-BIT_DEPTH){1'b0}}, win_q[r][c]}) * PW'(wt_q[r*3+c]);
            end
         end
         prod_valid_d = win_valid_q;
         prod_col_d   = win_col_q;
         out_valid_d  = prod_valid_q;
         out_col_d    = prod_col_q;
`ifdef CONV_RELU_EN
         out_data_d   = sum[SW-1] ? '0 : ACC_WIDTH'(sum);
`else
         out_data_d   = ACC_WIDTH'(sum);
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
         end
         for (int k = 0; k < 9; k++) begin
            wt_q[k]   <= '0;
            prod_q[k] <= '0;
         end
         col_cnt_q    <= '0;
         win_valid_q  <= 1'b0;
         win_col_q    <= '0;
         prod_valid_q <= 1'b0;
         prod_col_q   <= '0;
         out_valid_q  <= 1'b0;
         out_col_q    <= '0;
         out_data_q   <= '0;
      end else begin
         win_q        <= win_d;
         wt_q         <= wt_d;
         prod_q       <= prod_d;
         col_cnt_q    <= col_cnt_d;
         win_valid_q  <= win_valid_d;
         win_col_q    <= win_col_d;
         prod_valid_q <= prod_valid_d;
         prod_col_q   <= prod_col_d;
         out_valid_q  <= out_valid_d;
         out_col_q    <= out_col_d;
         out_data_q   <= out_data_d;
      end
   end
endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Randomised and directed bench for conv3x3_window_mac against a column-history reference model.
module tb_conv3x3_window_mac;
   localparam int BD   = 8;
   localparam int COLS = 28;
   localparam int AW   = 21;
   localparam int CW   = 5;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [BD-1:0] row1_in, row2_in, row3_in;
   logic          lb_shift;
   logic          row_start;
   logic          wt_load;
   logic [3:0]    wt_idx;
   logic [BD-1:0] wt_data;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_data;
   logic [CW-1:0] out_col;

   typedef struct {
      logic [AW-1:0] data;
      logic [CW-1:0] col;
      int            cyc;
   } result_t;

   result_t       expQ[$];
   logic [BD-1:0] hist [3][3];
   int            wtM [9];
   int            colIdx;
   int            cycle;
   int            handshakes;
   bit            latencyMode;
   bit            lastAccept;
   logic [BD-1:0] pixA [3][32];
   int            errors;
   int            checks;

   conv3x3_window_mac dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .row1_in(row1_in), .row2_in(row2_in), .row3_in(row3_in), .lb_shift(lb_shift),
      .row_start(row_start), .wt_load(wt_load), .wt_idx(wt_idx), .wt_data(wt_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_col(out_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input longint got, input longint expv);
      checks++;
      if (got != expv) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cycle);
      end
   endtask

   // Convolution of the last three accepted columns with the current kernel.
   function automatic logic [AW-1:0] windowSum();
      longint s = 0;
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 3; r++)
            s += longint'(hist[c][r]) * longint'(wtM[r*3+c]);
`ifdef CONV_RELU_EN
      if (s < 0) s = 0;
`endif
      return AW'(s);
   endfunction

   // One clock: drive, observe before the edge, then advance the model at the edge.
   task automatic applyStimulus(input logic rstV, input logic iv,
                                input logic [BD-1:0] p1, input logic [BD-1:0] p2, input logic [BD-1:0] p3,
                                input logic rs, input logic wl, input logic [3:0] wi,
                                input logic [BD-1:0] wd, input logic ordy);
      bit acc;
      int idx;
      rst_n = rstV; in_valid = iv; row1_in = p1; row2_in = p2; row3_in = p3;
      row_start = rs; wt_load = wl; wt_idx = wi; wt_data = wd; out_ready = ordy;
      @(negedge clk);
      checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
      checkOutput("lb_shift", lb_shift, in_valid && in_ready);
      acc = in_valid && in_ready;
      lastAccept = acc;
      if (out_valid) begin
         if (expQ.size() == 0) checkOutput("spurious", out_valid, 0);
         else begin
            checkOutput("out_data", out_data, expQ[0].data);
            checkOutput("out_col", out_col, expQ[0].col);
            if (latencyMode) checkOutput("latency", cycle, expQ[0].cyc + 2);
            if (out_ready) begin
               void'(expQ.pop_front());
               handshakes++;
            end
         end
      end else if (latencyMode && expQ.size() > 0 && cycle >= expQ[0].cyc + 2)
         checkOutput("late", out_valid, 1);
      @(posedge clk);
      cycle++;
      if (!rstV) begin
         expQ.delete();
         colIdx = 0;
         for (int k = 0; k < 9; k++) wtM[k] = 0;
      end else begin
         if (wl && wi < 4'd9) wtM[int'(wi)] = int'($signed(wd));
         if (acc) begin
            idx = rs ? 0 : colIdx;
            hist[0] = hist[1];
            hist[1] = hist[2];
            hist[2][0] = p1; hist[2][1] = p2; hist[2][2] = p3;
            colIdx = (idx + 1) % COLS;
            if (idx >= 2) expQ.push_back('{windowSum(), CW'(idx - 2), cycle});
         end else if (rs) colIdx = 0;
      end
      #1;
   endtask

   task automatic idle(input logic ordy);
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 4'd0, '0, ordy);
   endtask

   task automatic loadWeight(input int k, input int d);
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'(k), BD'(d), 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && expQ.size() > 0; i++) idle(1'b1);
      checkOutput("drain", expQ.size(), 0);
   endtask

   // Presents pixA columns, holding each until accepted, as a line buffer would.
   task automatic streamRow(input int nCols, input int stallAt, input int stallLen, input int rsAt,
                            input int wlAt, input int wlIdx, input int wlData);
      int  c = 0;
      int  cyc = 0;
      bit  ordy;
      while (c < nCols && cyc < 200) begin
         ordy = !(cyc >= stallAt && cyc < stallAt + stallLen);
         applyStimulus(1'b1, 1'b1, pixA[0][c], pixA[1][c], pixA[2][c], (c == rsAt) && ordy,
                       cyc == wlAt, 4'(wlIdx), BD'(wlData), ordy);
         if (lastAccept) c++;
         cyc++;
      end
      if (c < nCols) checkOutput("stream_timeout", c, nCols);
   endtask

   task automatic fillPix(input int mode);
      for (int c = 0; c < 32; c++)
         for (int r = 0; r < 3; r++)
            case (mode)
               0: pixA[r][c] = 8'd1;
               1: pixA[r][c] = BD'(c);
               2: pixA[r][c] = (c <= 5) ? 8'd0 : 8'd255;
               3: pixA[r][c] = 8'd7;
               default: pixA[r][c] = BD'($urandom);
            endcase
   endtask

   initial begin
      errors = 0; checks = 0; cycle = 0; colIdx = 0; handshakes = 0; latencyMode = 1'b1;
      for (int c = 0; c < 3; c++) for (int r = 0; r < 3; r++) hist[c][r] = '0;
      for (int k = 0; k < 9; k++) wtM[k] = 0;
      rst_n = 1'b0; in_valid = 1'b0; row1_in = '0; row2_in = '0; row3_in = '0;
      row_start = 1'b0; wt_load = 1'b0; wt_idx = '0; wt_data = '0; out_ready = 1'b1;

      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 4'd0, '0, 1'b1);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 4'd0, '0, 1'b1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_col", out_col, 0);

      $display("[TB] all-ones kernel over a full row");
      for (int k = 0; k < 9; k++) loadWeight(k, 1);
      fillPix(0);
      handshakes = 0;
      streamRow(28, -1, 0, 0, -1, 0, 0);
      drain();
      checkOutput("row_results", handshakes, 26);

      $display("[TB] horizontal gradient kernel on ramp and step");
      loadWeight(0, -1); loadWeight(1, 0); loadWeight(2, 1);
      loadWeight(3, -2); loadWeight(4, 0); loadWeight(5, 2);
      loadWeight(6, -1); loadWeight(7, 0); loadWeight(8, 1);
      fillPix(1);
      streamRow(28, -1, 0, 0, -1, 0, 0);
      drain();
      fillPix(2);
      streamRow(28, -1, 0, 0, -1, 0, 0);
      drain();

      $display("[TB] backpressure mid-row and weight load while stalled");
      latencyMode = 1'b0;
      fillPix(9);
      streamRow(28, 12, 5, 0, -1, 0, 0);
      idle(1'b1);
      idle(1'b0);
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1, 4'd4, 8'd100, 1'b0);
      idle(1'b0);
      drain();

      $display("[TB] row restart mid-row");
      latencyMode = 1'b1;
      for (int k = 0; k < 9; k++) loadWeight(k, int'($signed(BD'($urandom))));
      fillPix(9);
      streamRow(20, -1, 0, 11, -1, 0, 0);
      drain();

      $display("[TB] single-slot weight load during streaming");
      for (int k = 0; k < 9; k++) loadWeight(k, 0);
      fillPix(3);
      streamRow(28, -1, 0, 0, 5, 4, -3);
      drain();
      loadWeight(12, 8'h55);
      streamRow(12, -1, 0, 0, -1, 0, 0);
      drain();

      $display("[TB] randomised traffic");
      latencyMode = 1'b0;
      for (int k = 0; k < 9; k++) loadWeight(k, int'($signed(BD'($urandom))));
      for (int i = 0; i < 400; i++) begin
         bit ordy = ($urandom_range(0, 2) != 0);
         applyStimulus(1'b1, $urandom_range(0, 3) != 0, BD'($urandom), BD'($urandom), BD'($urandom),
                       ordy && ($urandom_range(0, 39) == 0), 1'b0, 4'd0, '0, ordy);
      end
      drain();

      $display("[TB] reset with results in flight");
      latencyMode = 1'b1;
      fillPix(9);
      streamRow(6, -1, 0, 0, -1, 0, 0);
      applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 4'd0, '0, 1'b1);
      checkOutput("midrst_out_valid", out_valid, 0);
      checkOutput("midrst_in_ready", in_ready, 1);
      fillPix(9);
      streamRow(10, -1, 0, 0, -1, 0, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
